regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the single-cycle and upcoming pipelined cores. It provides configurable width, depth and read-port count, and a hardwired zero register. Two prioritised write ports support ALU/load writeback, and a per-register pending scoreboard lets the pipelined core stall on RAW hazards. It sits between decode (read/issue) and writeback (write/clear).

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and write-request type for the register file.
// Optional write-to-read forwarding is selected in regfile_mp with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int ZERO_REG  = 0;

    // Upper bounds for the shared request type; XLEN <= 64 and NREGS <= 65536.
    localparam int MAX_XLEN = 64;
    localparam int MAX_AW   = 16;

    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    typedef struct packed {
        logic                en;
        logic [MAX_AW-1:0]   addr;
        logic [MAX_XLEN-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for RAW-hazard stalls: issue sets, committed writes clear,
// flush clears everything, and issue wins over both clear and flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int AW    = addr_width(NREGS)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    input  logic              flush,
    input  logic              clr_a_en,
    input  logic [AW-1:0]     clr_a_addr,
    input  logic              clr_b_en,
    input  logic [AW-1:0]     clr_b_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_pending,
    output logic              any_pending
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;

    // Apply in priority order: flush, then write clears, then issue on top.
    always_comb begin
        pending_next = flush ? '0 : pending;
        if (clr_a_en)
            pending_next[clr_a_addr] = 1'b0;
        if (clr_b_en)
            pending_next[clr_b_addr] = 1'b0;
        if (issue_en)
            pending_next[issue_addr] = 1'b1;
        pending_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_next;
    end

    always_comb begin
        rd_pending = '0;
        for (int k = 0; k < NRD; k++)
            rd_pending[k] = pending[rd_addr[k*AW +: AW]];
    end

    assign any_pending = |pending;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired r0, two prioritised write ports
// (B over A) and a pending scoreboard. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = addr_width(NREGS)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pending,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    input  logic                flush,
    output logic                any_pending
);

    logic [XLEN-1:0] regs [NREGS];
    wr_req_t         req_a;
    wr_req_t         req_b;
    logic [NRD-1:0]  sb_pending;
    logic            unused_bits;

    // A request only commits when enabled and aimed at a nonzero register.
    always_comb begin
        req_a      = '0;
        req_a.en   = wa_en && (wa_addr != AW'(ZERO_REG));
        req_a.addr = MAX_AW'(wa_addr);
        req_a.data = MAX_XLEN'(wa_data);
        req_b      = '0;
        req_b.en   = wb_en && (wb_addr != AW'(ZERO_REG));
        req_b.addr = MAX_AW'(wb_addr);
        req_b.data = MAX_XLEN'(wb_data);
    end

    assign unused_bits = &{1'b0, req_a.data, req_b.data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (req_b.en && (req_b.addr == MAX_AW'(i)))
                    regs[i] <= req_b.data[XLEN-1:0];
                else if (req_a.en && (req_a.addr == MAX_AW'(i)))
                    regs[i] <= req_a.data[XLEN-1:0];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .clr_a_en    (req_a.en),
        .clr_a_addr  (wa_addr),
        .clr_b_en    (req_b.en),
        .clr_b_addr  (wb_addr),
        .rd_addr     (rd_addr),
        .rd_pending  (sb_pending),
        .any_pending (any_pending)
    );

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset since the in-flight write is discarded.
    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] addr;
            logic          hit_a;
            logic          hit_b;
            addr  = rd_addr[k*AW +: AW];
            hit_a = rst_n && req_a.en && (req_a.addr == MAX_AW'(addr));
            hit_b = rst_n && req_b.en && (req_b.addr == MAX_AW'(addr));
            if (hit_b)
                rd_data[k*XLEN +: XLEN] = req_b.data[XLEN-1:0];
            else if (hit_a)
                rd_data[k*XLEN +: XLEN] = req_a.data[XLEN-1:0];
            else
                rd_data[k*XLEN +: XLEN] = regs[addr];
            if (hit_a || hit_b)
                rd_pending[k] = issue_en && (issue_addr == addr);
            else
                rd_pending[k] = sb_pending[k];
        end
    end
`else
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++)
            rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
    end

    assign rd_pending = sb_pending;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default XLEN=32, NREGS=32, NRD=2); expectations
// for same-cycle reads follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pending;
    logic                wa_en;
    logic [AW-1:0]       wa_addr;
    logic [XLEN-1:0]     wa_data;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic                flush;
    logic                any_pending;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_pending  (rd_pending),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .any_pending (any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    endtask

    task automatic set_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        set_reads(5'd5, 5'd6);
        #3;
        check_output("reset_rd0", rd_data[31:0], 32'h0);
        check_output("reset_any", {31'b0, any_pending}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset: write r5 and issue r6, then reset mid-cycle with the same requests live.
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h5;
        issue_en = 1'b1; issue_addr = 5'd6;
        apply_stimulus();
        check_output("pre_rst_r5", rd_data[31:0], 32'h5);
        check_output("pre_rst_pend6", {31'b0, rd_pending[1]}, 32'h1);
        check_output("pre_rst_any", {31'b0, any_pending}, 32'h1);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h7;
        issue_en = 1'b1; issue_addr = 5'd6;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_rd0", rd_data[31:0], 32'h0);
        check_output("rst_rd1", rd_data[63:32], 32'h0);
        check_output("rst_pend", {30'b0, rd_pending}, 32'h0);
        check_output("rst_any", {31'b0, any_pending}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        check_output("rst_discard_r5", rd_data[31:0], 32'h0);
        check_output("rst_discard_any", {31'b0, any_pending}, 32'h0);

        // Zero register is never written and never pending.
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hDEADBEEF;
        issue_en = 1'b1; issue_addr = 5'd0;
        set_reads(5'd0, 5'd0);
        apply_stimulus();
        check_output("r0_data", rd_data[31:0], 32'h0);
        check_output("r0_pend", {30'b0, rd_pending}, 32'h0);
        check_output("r0_any", {31'b0, any_pending}, 32'h0);

        // Write collisions: B wins on same address, distinct addresses both land.
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h11;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h22;
        set_reads(5'd3, 5'd0);
        apply_stimulus();
        check_output("collide_r3", rd_data[31:0], 32'h22);
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h33;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h44;
        set_reads(5'd4, 5'd7);
        apply_stimulus();
        check_output("dual_r4", rd_data[31:0], 32'h33);
        check_output("dual_r7", rd_data[63:32], 32'h44);

        // Scoreboard: issue latency, issue-beats-write, later write clears.
        issue_en = 1'b1; issue_addr = 5'd9;
        set_reads(5'd9, 5'd0);
        #1;
        check_output("issue_same_cycle", {31'b0, rd_pending[0]}, 32'h0);
        apply_stimulus();
        check_output("issue_next_cycle", {31'b0, rd_pending[0]}, 32'h1);
        wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h99;
        issue_en = 1'b1; issue_addr = 5'd9;
        apply_stimulus();
        check_output("reissue_data", rd_data[31:0], 32'h99);
        check_output("reissue_pend", {31'b0, rd_pending[0]}, 32'h1);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h100;
        apply_stimulus();
        check_output("clear_data", rd_data[31:0], 32'h100);
        check_output("clear_pend", {31'b0, rd_pending[0]}, 32'h0);
        check_output("clear_any", {31'b0, any_pending}, 32'h0);

        // Flush together with issue leaves only the issued register pending.
        issue_en = 1'b1; issue_addr = 5'd2;
        apply_stimulus();
        issue_en = 1'b1; issue_addr = 5'd8;
        apply_stimulus();
        issue_en = 1'b1; issue_addr = 5'd10;
        apply_stimulus();
        set_reads(5'd2, 5'd8);
        #1;
        check_output("pre_flush_pend", {30'b0, rd_pending}, 32'h3);
        flush = 1'b1;
        issue_en = 1'b1; issue_addr = 5'd12;
        apply_stimulus();
        check_output("flush_pend_2_8", {30'b0, rd_pending}, 32'h0);
        set_reads(5'd10, 5'd12);
        #1;
        check_output("flush_pend_10_12", {30'b0, rd_pending}, 32'h2);
        check_output("flush_any", {31'b0, any_pending}, 32'h1);
        set_reads(5'd3, 5'd4);
        #1;
        check_output("flush_keeps_r3", rd_data[31:0], 32'h22);
        check_output("flush_keeps_r4", rd_data[63:32], 32'h33);
        flush = 1'b1;
        apply_stimulus();
        check_output("flush_alone_any", {31'b0, any_pending}, 32'h0);

        // Same-cycle read of a register being written, on every read port.
        issue_en = 1'b1; issue_addr = 5'd6;
        set_reads(5'd6, 5'd6);
        apply_stimulus();
        check_output("byp_pre_pend", {31'b0, rd_pending[0]}, 32'h1);
        wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'hA5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_output("byp_rd0", rd_data[31:0], 32'hA5A5);
        check_output("byp_rd1", rd_data[63:32], 32'hA5A5);
        check_output("byp_pend", {31'b0, rd_pending[0]}, 32'h0);
`else
        check_output("byp_rd0", rd_data[31:0], 32'h0);
        check_output("byp_rd1", rd_data[63:32], 32'h0);
        check_output("byp_pend", {31'b0, rd_pending[0]}, 32'h1);
`endif
        apply_stimulus();
        check_output("byp_next_rd0", rd_data[31:0], 32'hA5A5);
        check_output("byp_next_rd1", rd_data[63:32], 32'hA5A5);
        check_output("byp_next_pend", {31'b0, rd_pending[0]}, 32'h0);
        wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h1;
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h2;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_output("byp_prio", rd_data[31:0], 32'h2);
`else
        check_output("byp_prio", rd_data[31:0], 32'hA5A5);
`endif
        apply_stimulus();
        check_output("byp_prio_next", rd_data[63:32], 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
